// File: rtl/musb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// musb_mem_arbiter
//   Round-robin arbiter that multiplexes a core's instruction port (ci_*) and
//   data port (cd_*) onto one shared memory request port (m_*). Only one
//   transfer is in flight at a time, and at least one IDLE cycle separates two
//   transfers.
//
//   Parameters
//     TIMEOUT_CYCLES : cycles a grant waits for m_ready/m_error before a forced
//                      error (1..65535; used only with MUSB_ARB_TIMEOUT_EN).
//
//   Configuration macro
//     MUSB_ARB_TIMEOUT_EN : when defined, builds a 16-bit watchdog that ends a
//                           stalled grant with an error strobe. When undefined,
//                           a grant waits indefinitely.
//
//   Ports
//     clk, rst                          : clock, synchronous active-high reset
//     ci_address/ci_wr/ci_enable        : instruction-port request
//     ci_data/ci_ready/ci_error         : instruction-port response
//     cd_address/cd_data_w/cd_wr/cd_enable : data-port request
//     cd_data/cd_ready/cd_error         : data-port response
//     m_address/m_data_w/m_wr/m_enable  : shared memory request
//     m_data/m_ready/m_error            : shared memory response
//
//   Request mux and ready/error strobes are combinational so that a memory
//   completion reaches the core in the same cycle.
// -----------------------------------------------------------------------------
module musb_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // instruction port
    input  logic [31:0] ci_address,
    input  logic [3:0]  ci_wr,
    input  logic        ci_enable,
    output logic [31:0] ci_data,
    output logic        ci_ready,
    output logic        ci_error,
    // data port
    input  logic [31:0] cd_address,
    input  logic [31:0] cd_data_w,
    input  logic [3:0]  cd_wr,
    input  logic        cd_enable,
    output logic [31:0] cd_data,
    output logic        cd_ready,
    output logic        cd_error,
    // shared memory port
    output logic [31:0] m_address,
    output logic [31:0] m_data_w,
    output logic [3:0]  m_wr,
    output logic        m_enable,
    input  logic [31:0] m_data,
    input  logic        m_ready,
    input  logic        m_error
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned WW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    // Empty marker block: present in the elaborated hierarchy only when the
    // timeout setting is outside its legal range.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_out_of_range
    end

    state_e state_q, state_d;
    logic   last_d_q, last_d_d;   // 1: data port was granted last

`ifdef MUSB_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W     = 16;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Signals of whichever port currently owns the bus.
    logic          g_enable;
    logic [AW-1:0] g_address;
    logic [WW-1:0] g_wr;
    logic [DW-1:0] g_data_w;
    logic          g_ready;
    logic          g_error;

    // Read data fans out to both ports; the strobes tell each port when it is valid.
    assign ci_data = m_data;
    assign cd_data = m_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
`ifdef MUSB_ARB_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
`ifdef MUSB_ARB_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Next-state, request mux and response routing
    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
`ifdef MUSB_ARB_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        g_enable  = 1'b0;
        g_address = '0;
        g_wr      = '0;
        g_data_w  = '0;
        g_ready   = 1'b0;
        g_error   = 1'b0;
        m_enable  = 1'b0;
        m_address = '0;
        m_wr      = '0;
        m_data_w  = '0;
        ci_ready  = 1'b0;
        ci_error  = 1'b0;
        cd_ready  = 1'b0;
        cd_error  = 1'b0;

        // Select the granted port (the instruction port never writes data).
        case (state_q)
            GNT_I: begin
                g_enable  = ci_enable;
                g_address = ci_address;
                g_wr      = ci_wr;
            end
            GNT_D: begin
                g_enable  = cd_enable;
                g_address = cd_address;
                g_wr      = cd_wr;
                g_data_w  = cd_data_w;
            end
            default: ;
        endcase

        if (state_q == IDLE) begin
`ifdef MUSB_ARB_TIMEOUT_EN
            tmo_d = '0;
`endif
            // On a tie, grant the port that did not win last time.
            if (ci_enable && (!cd_enable || last_d_q)) begin
                state_d  = GNT_I;
                last_d_d = 1'b0;
            end else if (cd_enable) begin
                state_d  = GNT_D;
                last_d_d = 1'b1;
            end
        end else begin
            m_address = g_address;
            m_wr      = g_wr;
            m_data_w  = g_data_w;
            if (!g_enable) begin
                // Flush: abandon the transfer, any m_ready this cycle is dropped.
                state_d = IDLE;
            end else if (m_error) begin
                m_enable = 1'b1;
                g_error  = 1'b1;
                state_d  = IDLE;
            end else if (m_ready) begin
                m_enable = 1'b1;
                g_ready  = 1'b1;
                state_d  = IDLE;
            end else begin
`ifdef MUSB_ARB_TIMEOUT_EN
                if (tmo_q == TMO_LIMIT) begin
                    g_error = 1'b1;
                    state_d = IDLE;
                end else begin
                    m_enable = 1'b1;
                    tmo_d    = tmo_q + TMO_W'(1);
                end
`else
                m_enable = 1'b1;
`endif
            end
        end

        ci_ready = g_ready && (state_q == GNT_I);
        ci_error = g_error && (state_q == GNT_I);
        cd_ready = g_ready && (state_q == GNT_D);
        cd_error = g_error && (state_q == GNT_D);

        // Reset silences the bus and all strobes in the same cycle.
        if (rst) begin
            m_enable  = 1'b0;
            m_address = '0;
            m_wr      = '0;
            m_data_w  = '0;
            ci_ready  = 1'b0;
            ci_error  = 1'b0;
            cd_ready  = 1'b0;
            cd_error  = 1'b0;
        end
    end

endmodule
